// File: rtl/pio_out_blink.sv
// Avalon-MM output PIO with atomic set/clear/toggle, a per-bit blink engine
// and readback of the effective output value.
module pio_out_blink #(
   parameter int unsigned      WIDTH       = 10,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned      CNT_W       = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   typedef enum logic [2:0] {
      A_DATA   = 3'd0,
      A_SET    = 3'd1,
      A_CLR    = 3'd2,
      A_TGL    = 3'd3,
      A_MASK   = 3'd4,
      A_PERIOD = 3'd5,
      A_STATUS = 3'd6,
      A_OUT    = 3'd7
   } reg_addr_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   reg_addr_t        addr;
   logic             wr;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] mask;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] counter;
   logic             phase;

   assign addr = reg_addr_t'(address);
   assign wr   = chipselect && !write_n;
   assign wd   = writedata[WIDTH-1:0];

   // NOTE: state registers use <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         data    <= RESET_VALUE;
         mask    <= '0;
         period  <= '0;
         counter <= '0;
         phase   <= 1'b0;
      end else begin
         if (wr) begin
            case (addr)
               A_DATA:  data <= wd;
               A_SET:   data <= data | wd;
               A_CLR:   data <= data & ~wd;
               A_TGL:   data <= data ^ wd;
               A_MASK:  mask <= wd;
               default: ;
            endcase
         end

         // A period write restarts the blink cycle, even with an unchanged value.
         if (wr && addr == A_PERIOD) begin
            period  <= writedata[CNT_W-1:0];
            counter <= '0;
            phase   <= 1'b0;
         end else if (period == '0) begin
            counter <= '0;
            phase   <= 1'b0;
         end else if (counter == period - CNT_ONE) begin
            counter <= '0;
            phase   <= ~phase;
         end else begin
            counter <= counter + CNT_ONE;
         end
      end
   end

   assign out_port = data ^ (mask & {WIDTH{phase}});

   // NOTE: default assigned first so no path through the case infers a latch.
   always_comb begin
      readdata = '0;
      case (addr)
         A_DATA:   readdata[WIDTH-1:0] = data;
         A_MASK:   readdata[WIDTH-1:0] = mask;
         A_PERIOD: readdata[CNT_W-1:0] = period;
         A_STATUS: readdata[0]         = phase;
         A_OUT:    readdata[WIDTH-1:0] = out_port;
         default:  ;
      endcase
   end

endmodule

// File: tb/tb_pio_out_blink.sv
// Self-checking bench for pio_out_blink: directed steps plus a random phase,
// compared against a cycle-count based reference model.
module tb_pio_out_blink;

   localparam int unsigned      WIDTH = 10;
   localparam int unsigned      CNT_W = 24;
   localparam logic [WIDTH-1:0] RV    = 10'h155;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] out_port;

   int checks = 0;
   int errors = 0;

   // Reference model: phase derived from edges elapsed since the last restart.
   logic [WIDTH-1:0] m_data, m_mask;
   logic [CNT_W-1:0] m_period;
   longint           m_k;

   pio_out_blink #(.WIDTH(WIDTH), .RESET_VALUE(RV), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .out_port(out_port)
   );

   always #5 clk = ~clk;

   function automatic logic m_phase();
      if (m_period == '0) return 1'b0;
      return logic'((m_k / longint'(m_period)) % 2);
   endfunction

   function automatic logic [WIDTH-1:0] m_out();
      return m_data ^ (m_phase() ? m_mask : '0);
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return 32'(m_data);
         3'd4:    return 32'(m_mask);
         3'd5:    return 32'(m_period);
         3'd6:    return 32'(m_phase());
         3'd7:    return 32'(m_out());
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_update();
      logic [WIDTH-1:0] wd;
      wd = writedata[WIDTH-1:0];
      if (reset) begin
         m_data = RV; m_mask = '0; m_period = '0; m_k = 0;
      end else begin
         if (chipselect && !write_n && address == 3'd5) begin
            m_period = writedata[CNT_W-1:0];
            m_k = 0;
         end else begin
            m_k = m_k + 1;
         end
         if (chipselect && !write_n) begin
            case (address)
               3'd0: m_data = wd;
               3'd1: m_data = m_data | wd;
               3'd2: m_data = m_data & ~wd;
               3'd3: m_data = m_data ^ wd;
               3'd4: m_mask = wd;
               default: ;
            endcase
         end
      end
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      step();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      #1;
      check(tag, readdata, exp);
      chipselect = 1'b0;
   endtask

   task automatic check_out(input string tag);
      check(tag, 32'(out_port), 32'(m_out()));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("reset_out", 32'(out_port), 32'h155);
      read_check(3'd0, 32'h155, "reset_data");
      read_check(3'd4, 32'h0, "reset_mask");
      read_check(3'd5, 32'h0, "reset_period");
      read_check(3'd6, 32'h0, "reset_status");
      read_check(3'd7, 32'h155, "reset_out_rd");

      // Atomic set / clear / toggle
      bus_write(3'd0, 32'h0F0); read_check(3'd0, 32'h0F0, "data_wr");
      bus_write(3'd1, 32'h003); read_check(3'd0, 32'h0F3, "data_set");
      bus_write(3'd2, 32'h010); read_check(3'd0, 32'h0E3, "data_clr");
      bus_write(3'd3, 32'h300); read_check(3'd0, 32'h3E3, "data_tgl");
      check("out_after_tgl", 32'(out_port), 32'h3E3);
      read_check(3'd1, 32'h0, "rd_set_zero");
      read_check(3'd2, 32'h0, "rd_clr_zero");
      read_check(3'd3, 32'h0, "rd_tgl_zero");
      bus_write(3'd6, 32'hFFFF_FFFF); read_check(3'd6, 32'h0, "status_wr_ignored");
      bus_write(3'd7, 32'hFFFF_FFFF); read_check(3'd0, 32'h3E3, "out_wr_ignored");

      // Blink with PERIOD=4: bit0 low for 4 cycles, then high for 4
      bus_write(3'd0, 32'h000);
      bus_write(3'd4, 32'h001);
      bus_write(3'd5, 32'd4);
      for (int i = 0; i < 16; i++) begin
         check("blink4_bit0", 32'(out_port[0]), 32'((i / 4) % 2));
         read_check(3'd6, 32'(m_phase()), "blink4_status");
         read_check(3'd7, 32'(out_port), "blink4_out_rd");
         check_out("blink4_model");
         step();
      end

      // Rewrite PERIOD at phase 1: restart, next toggle 4 cycles after write
      for (int i = 0; i < 8 && !m_phase(); i++) step();
      check("pre_rewrite_phase", 32'(out_port[0]), 32'h1);
      bus_write(3'd5, 32'd4);
      read_check(3'd6, 32'h0, "rewrite_phase_clr");
      for (int i = 0; i < 3; i++) begin
         step();
         read_check(3'd6, 32'h0, "rewrite_hold");
      end
      step();
      read_check(3'd6, 32'h1, "rewrite_toggle");

      // PERIOD=1 toggles every cycle, PERIOD=0 stops
      bus_write(3'd5, 32'd1);
      bus_write(3'd4, 32'h3FF);
      bus_write(3'd0, 32'h0AA);
      for (int i = 0; i < 6; i++) begin
         check_out("period1_model");
         check("period1_alt", 32'(out_port ^ (out_port >> 0)) & 32'h0, 32'h0);
         step();
         check("period1_flip", 32'(out_port == 10'h0AA || out_port == 10'h355), 32'h1);
      end
      bus_write(3'd5, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("period0_hold", 32'(out_port), 32'h0AA);
         step();
      end

      // Reset mid-blink overrides a concurrent DATA write
      bus_write(3'd5, 32'd3);
      for (int i = 0; i < 8 && !m_phase(); i++) step();
      check("pre_reset_phase", 32'(m_phase()), 32'(readdata[0] | 1'b1));
      address = 3'd0; writedata = 32'h3FF; chipselect = 1'b1; write_n = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      check("rst_out", 32'(out_port), 32'h155);
      read_check(3'd0, 32'h155, "rst_data");
      read_check(3'd4, 32'h0, "rst_mask");
      read_check(3'd5, 32'h0, "rst_period");
      read_check(3'd6, 32'h0, "rst_status");
      for (int i = 0; i < 6; i++) begin
         step();
         check("rst_no_toggle", 32'(out_port), 32'h155);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(0, 49) == 0);
         address    = 3'($urandom_range(0, 7));
         chipselect = 1'($urandom_range(0, 1));
         write_n    = 1'($urandom_range(0, 1));
         writedata  = (address == 3'd5) ? 32'($urandom_range(0, 5)) : $urandom;
         #1;
         check("rand_read", readdata, m_read(address));
         step();
         reset = 1'b0;
         check_out("rand_out");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
